// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle control FSM and its datapath / memories.
// The control side uses the master modport and the datapath side uses the slave modport.
interface multicycle_control_if;
    // Handshakes:
    // - instr_valid/fetch_req: an instruction is accepted only in a FETCH cycle where
    //   fetch_req and instr_valid are both high. instr_valid in any other cycle is ignored.
    // - mem_ready/mem_rd|mem_wr: the strobe stays high until the cycle in which mem_ready is
    //   high. mem_ready in any other cycle is ignored.
    logic [15:0] instr;
    logic        instr_valid;
    logic        zero;
    logic        mem_ready;
    logic        fetch_req;
    logic [3:0]  RA;
    logic [3:0]  RB;
    logic [3:0]  RW;
    logic        En;
    logic        EnW;
    logic        src_sel;
    logic [2:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        wb_sel;
    logic        pc_wr;
    logic        pc_src;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;

    modport master (
        input  instr, instr_valid, zero, mem_ready,
        output fetch_req, RA, RB, RW, En, EnW, src_sel, alu_op,
               mem_rd, mem_wr, wb_sel, pc_wr, pc_src, state, halted, illegal
    );

    modport slave (
        output instr, instr_valid, zero, mem_ready,
        input  fetch_req, RA, RB, RW, En, EnW, src_sel, alu_op,
               mem_rd, mem_wr, wb_sel, pc_wr, pc_src, state, halted, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit datapath.
// Optional ZERO_REG_EN: R0 is hard-wired, so write-backs to R0 keep EnW low.
module multicycle_control #(
    parameter int OPW   = 4,
    parameter int REGAW = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } stateT;

    localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
    localparam logic [OPW-1:0] OP_LW   = OPW'(5);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(7);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(8);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    stateT            stateQ;
    stateT            stateD;
    logic [15:0]      ir;
    logic             illegalQ;
    logic [OPW-1:0]   op;
    logic [REGAW-1:0] rd;
    logic [REGAW-1:0] rs1;
    logic [REGAW-1:0] rs2;
    logic             isRType;
    logic             isAddi;
    logic             isLw;
    logic             isSw;
    logic             isBeq;
    logic             isJmp;
    logic             isHalt;
    logic             isIllegal;
    logic [REGAW-1:0] rbAddr;

    assign op  = ir[15:12];
    assign rd  = ir[11:8];
    assign rs1 = ir[7:4];
    assign rs2 = ir[3:0];

    assign isRType   = (op < OP_ADDI);
    assign isAddi    = (op == OP_ADDI);
    assign isLw      = (op == OP_LW);
    assign isSw      = (op == OP_SW);
    assign isBeq     = (op == OP_BEQ);
    assign isJmp     = (op == OP_JMP);
    assign isHalt    = (op == OP_HALT);
    assign isIllegal = (op > OP_JMP) && !isHalt;

    // SW and BEQ read their second operand from the rd field.
    assign rbAddr = isRType ? rs2 : ((isSw || isBeq) ? rd : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= FETCH;
            ir       <= '0;
            illegalQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (stateQ == FETCH && bus.instr_valid) begin
                ir <= bus.instr;
            end
            if (stateQ == DECODE && isIllegal) begin
                illegalQ <= 1'b1;
            end
        end
    end

    always_comb begin
        stateD        = stateQ;
        bus.fetch_req = 1'b0;
        bus.RA        = '0;
        bus.RB        = '0;
        bus.RW        = '0;
        bus.En        = 1'b0;
        bus.EnW       = 1'b0;
        bus.src_sel   = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.wb_sel    = 1'b0;
        bus.pc_wr     = 1'b0;
        bus.pc_src    = 1'b0;
        bus.state     = stateQ;
        bus.halted    = (stateQ == HALT);
        bus.illegal   = illegalQ;

        case (stateQ)
            FETCH: begin
                bus.fetch_req = 1'b1;
                bus.pc_wr     = bus.instr_valid;
                if (bus.instr_valid) begin
                    stateD = DECODE;
                end
            end
            DECODE: begin
                bus.En = 1'b1;
                bus.RA = rs1;
                bus.RB = rbAddr;
                if (isHalt || isIllegal) begin
                    stateD = HALT;
                end else if (isJmp) begin
                    bus.pc_wr  = 1'b1;
                    bus.pc_src = 1'b1;
                    stateD     = FETCH;
                end else begin
                    stateD = EXEC;
                end
            end
            EXEC: begin
                bus.En = 1'b1;
                bus.RA = rs1;
                bus.RB = rbAddr;
                if (isRType) begin
                    bus.alu_op = {1'b0, op[1:0]};
                    stateD     = WB;
                end else if (isBeq) begin
                    bus.alu_op = ALU_SUB;
                    bus.pc_wr  = bus.zero;
                    bus.pc_src = 1'b1;
                    stateD     = FETCH;
                end else begin
                    bus.src_sel = 1'b1;
                    stateD      = isAddi ? WB : MEM;
                end
            end
            MEM: begin
                bus.mem_rd = isLw;
                bus.mem_wr = isSw;
                if (bus.mem_ready) begin
                    stateD = isLw ? WB : FETCH;
                end
            end
            WB: begin
                bus.RW     = rd;
                bus.wb_sel = isLw;
`ifdef ZERO_REG_EN
                bus.EnW    = (rd != '0);
`else
                bus.EnW    = 1'b1;
`endif
                stateD     = FETCH;
            end
            HALT: begin
                stateD = HALT;
            end
            default: begin
                stateD = FETCH;
            end
        endcase

        // Reset forces every output low immediately, including in-flight strobes.
        if (!rst_n) begin
            bus.fetch_req = 1'b0;
            bus.RA        = '0;
            bus.RB        = '0;
            bus.RW        = '0;
            bus.En        = 1'b0;
            bus.EnW       = 1'b0;
            bus.src_sel   = 1'b0;
            bus.alu_op    = '0;
            bus.mem_rd    = 1'b0;
            bus.mem_wr    = 1'b0;
            bus.wb_sel    = 1'b0;
            bus.pc_wr     = 1'b0;
            bus.pc_src    = 1'b0;
            bus.state     = '0;
            bus.halted    = 1'b0;
            bus.illegal   = 1'b0;
        end
    end
endmodule
